// File: rtl/pattern_scan_ctrl.sv
// Word-to-bit sequencer for the serial pattern detector: accepts words over valid/ready,
// shifts them out MSB-first through an overlapping-match detector, and counts hits.
module pattern_scan_ctrl #(
    parameter int unsigned     WORD_W  = 8,
    parameter int unsigned     PAT_W   = 4,
    parameter int unsigned     CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = 4'b1011
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         cfg_we,
    input  logic [PAT_W-1:0]             cfg_pattern,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WORD_W-1:0]            in_data,
    input  logic                         cnt_clr,
    output logic                         busy,
    output logic                         match,
    output logic                         done,
    output logic [$clog2(WORD_W+1)-1:0]  word_matches,
    output logic [CNT_W-1:0]             match_cnt
);

    localparam int unsigned WM_W   = $clog2(WORD_W + 1);
    localparam int unsigned IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WM_W-1:0]   wcnt_q, wcnt_d;
    logic [WM_W-1:0]   wm_q, wm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              match_q, match_d;

    logic              bit_in;
    logic [PAT_W-1:0]  cand;
    logic              hit;

    assign bit_in = shreg_q[WORD_W-1];
    assign cand   = {hist_q, bit_in};
    // fill gate keeps stale zeros in a freshly cleared history from forming a match
    assign hit    = (state_q == SHIFT) && (cand == pattern_q) &&
                    (fill_q >= FILL_W'(PAT_W - 1));

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        shreg_d   = shreg_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        idx_d     = idx_q;
        wcnt_d    = wcnt_q;
        wm_d      = wm_q;
        match_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    shreg_d = in_data;
                    idx_d   = IDX_W'(WORD_W - 1);
                    wcnt_d  = '0;
                    state_d = SHIFT;
                end else if (cfg_we) begin
                    pattern_d = cfg_pattern;
                    hist_d    = '0;
                    fill_d    = '0;
                end
            end
            SHIFT: begin
                hist_d  = cand[PAT_W-2:0];
                shreg_d = shreg_q << 1;
                if (fill_q != FILL_W'(PAT_W)) begin
                    fill_d = fill_q + 1'b1;
                end
                if (hit) begin
                    match_d = 1'b1;
                    wcnt_d  = wcnt_q + 1'b1;
                end
                if (idx_q == '0) begin
                    wm_d    = wcnt_d;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            pattern_q <= RST_PAT;
            shreg_q   <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            idx_q     <= '0;
            wcnt_q    <= '0;
            wm_q      <= '0;
            cnt_q     <= '0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            shreg_q   <= shreg_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            idx_q     <= idx_d;
            wcnt_q    <= wcnt_d;
            wm_q      <= wm_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign match        = match_q;
    assign word_matches = wm_q;
    assign match_cnt    = cnt_q;

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
Sequencer for the serial pattern detector datapath. It accepts parallel words over a valid/ready handshake and serializes each word MSB-first into a programmable overlapping-match detector. It counts matches per word and in total, and reports completion per word. It sits between a word-oriented producer and the bit-serial detection logic, and owns the detector's pattern configuration.

Parameters:
WORD_W, 8, bits per input word, serialized MSB-first; must be >= 1
PAT_W, 4, pattern length in bits; must be >= 2
CNT_W, 8, width of total match counter
RST_PAT, 4'b1011, pattern value loaded at reset, PAT_W bits

Ports:
clk  input  1  clock; all logic on rising edge
rstn  input  1  synchronous active-low reset
cfg_we  input  1  pattern write strobe; honored only in IDLE
cfg_pattern  input  PAT_W  new pattern; bit PAT_W-1 is the oldest bit of the stream
in_valid  input  1  producer has a word
in_ready  output  1  block can accept a word
in_data  input  WORD_W  word to scan
cnt_clr  input  1  clear match_cnt
busy  output  1  scan in progress (SHIFT or DONE)
match  output  1  one-cycle pulse per detected pattern occurrence
done  output  1  one-cycle pulse at end of each word
word_matches  output  $clog2(WORD_W+1)  matches found in the last completed word
match_cnt  output  CNT_W  saturating total match count

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE, pattern=RST_PAT, shift register=0, history=0, fill=0, bit index=0, word_matches=0, match_cnt=0, match=0, done=0. Reset applies in any state, including mid-SHIFT; any partial word is discarded.
- in_ready = (state==IDLE), combinational from state. busy = (state!=IDLE).
- IDLE:
  - If in_valid & in_ready: capture in_data, bit index=WORD_W-1, per-word counter=0, go to SHIFT.
  - Else if cfg_we: pattern<=cfg_pattern, history<=0, fill<=0.
- SHIFT, one bit per cycle:
  - b = shift register MSB.
  - history <= {history[PAT_W-2:0], b}; shift register shifts left.
  - fill increments and saturates at PAT_W.
  - Hit condition: {history[PAT_W-2:0], b}==pattern and fill>=PAT_W-1.
  - On a hit, in the same edge: match<=1, per-word counter +1, match_cnt +1 (saturating at all-ones). Otherwise match<=0.
  - Overlapping matches count.
  - After the bit with index 0, go to DONE.
  - cfg_we is ignored in SHIFT and DONE; it has no effect and no latching.
- DONE, one cycle: done=1, word_matches<=per-word counter (visible from this cycle until the next DONE), then go to IDLE.
- Latency and throughput: the match pulse is asserted in the cycle after the edge that consumed the completing bit. Word cycle = 1 (accept) + WORD_W (SHIFT) + 1 (DONE) = WORD_W+2 clocks; a new word can be accepted on the cycle after DONE.
- Stream continuity: history and fill persist across words. A pattern straddling a word boundary is detected and counted in the later word. Only reset or a cfg write clears history.
- match is 0 in all states except the cycle following a SHIFT hit; done is 0 except in DONE.
- cnt_clr clears match_cnt in any state. If it coincides with a hit, the result is 0 (clear wins).
- in_data is sampled only at acceptance. Changes to in_data or in_valid during busy have no effect.

Test Plan:
1. Reset, WORD_W=8, default pattern 1011. Send 8'b1011_0110 → match pulses 4 and 7 cycles after the accept edge, done once, word_matches=2, match_cnt=2.
2. Boundary straddle: send 8'b0000_0101, then 8'b1000_0000 → first word word_matches=0; second word word_matches=1 with its match on the first bit of that word; match_cnt=1.
3. Backpressure: hold in_valid=1 with word A then word B continuously → in_ready low for exactly WORD_W+1 cycles per word; B is accepted the cycle after A's done; both words are processed intact.
4. Config: in IDLE write cfg_pattern=4'b1111, then send 8'hFF → 5 matches, word_matches=5. Write cfg_we during SHIFT with 4'b0000 → ignored; a following 8'hFF with history continuing still gives 8 matches.
5. Saturation and clear, CNT_W=2, pattern 4'b1111: send 8'hFF → match_cnt saturates at 3 while word_matches=5. Pulse cnt_clr coincident with a hit → match_cnt=0.
6. Reset mid-operation: drop rstn on the 3rd SHIFT cycle → next cycle state is IDLE, in_ready=1, match_cnt=0, pattern=1011, and no done pulse occurs. A subsequent 8'b1011_0110 yields word_matches=2.
